// File: rtl/iob_timer_mc_pkg.sv
// Register map and CTRL bit positions shared by the timer top and its channels.
package iob_timer_mc_pkg;

    // Per-channel register offsets (address[2:0])
    localparam logic [2:0] RegCtrl    = 3'd0;
    localparam logic [2:0] RegLoadLo  = 3'd1;
    localparam logic [2:0] RegLoadHi  = 3'd2;
    localparam logic [2:0] RegCountLo = 3'd3;
    localparam logic [2:0] RegCountHi = 3'd4;
    localparam logic [2:0] RegStatus  = 3'd5;

    // Global region registers (channel index == N_CH)
    localparam logic [2:0] RegPresc   = 3'd0;
    localparam logic [2:0] RegPendAll = 3'd1;

    // CTRL bit positions
    localparam int unsigned CtrlEn    = 0;
    localparam int unsigned CtrlMode  = 1;
    localparam int unsigned CtrlIrqEn = 2;
    localparam int unsigned CtrlW     = 3;

endpackage

// File: rtl/iob_timer_mc_ch.sv
// One timer channel: CTRL/LOAD/COUNT/PEND registers, high-word read shadow and read mux.
module iob_timer_mc_ch
    import iob_timer_mc_pkg::*;
#(
    parameter int unsigned CNT_W  = 48,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              tick_i,
    input  logic              wr_i,
    input  logic              rd_i,
    input  logic [2:0]        reg_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              pend_o,
    output logic              irq_o
);

    // LOAD/COUNT are held two bus words wide; bits at and above CNT_W are forced to zero
    localparam int unsigned W2 = 2 * DATA_W;
    localparam logic [W2-1:0] CntMask = {W2{1'b1}} >> (W2 - CNT_W);

    logic [CtrlW-1:0]  ctrl_q, ctrl_d;
    logic [W2-1:0]     load_q, load_d;
    logic [W2-1:0]     count_q, count_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic              pend_q, pend_d;
    logic              en_rise, run_tick, evt;

    // A rising EN write has priority over a coincident tick: count is loaded, not decremented
    assign en_rise  = wr_i && (reg_i == RegCtrl) && wdata_i[CtrlEn] && !ctrl_q[CtrlEn];
    assign run_tick = tick_i && ctrl_q[CtrlEn];
    assign evt      = run_tick && (count_q == '0);

    // Next-state for all channel registers
    always_comb begin
        ctrl_d   = ctrl_q;
        load_d   = load_q;
        count_d  = count_q;
        pend_d   = pend_q;
        shadow_d = shadow_q;

        if (wr_i) begin
            case (reg_i)
                RegCtrl:   ctrl_d = wdata_i[CtrlW-1:0];
                RegLoadLo: load_d[DATA_W-1:0] = wdata_i;
                RegLoadHi: load_d[W2-1:DATA_W] = wdata_i;
                RegStatus: if (wdata_i[0]) pend_d = 1'b0;
                default: ;
            endcase
        end
        load_d = load_d & CntMask;

        // Latch the high word so a following COUNT_HI read matches this COUNT_LO read
        if (rd_i && (reg_i == RegCountLo)) begin
            shadow_d = count_q[W2-1:DATA_W];
        end

        if (en_rise) begin
            count_d = load_q;
        end else if (run_tick) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end else if (ctrl_q[CtrlMode]) begin
                count_d = '0;
            end else begin
                count_d = load_q;
            end
        end

        // Event beats a same-cycle W1C and a same-cycle CTRL write
        if (evt) begin
            pend_d = 1'b1;
            if (ctrl_q[CtrlMode]) begin
                ctrl_d[CtrlEn] = 1'b0;
            end
        end
    end

    // Channel state registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ctrl_q   <= '0;
            load_q   <= '0;
            count_q  <= '0;
            shadow_q <= '0;
            pend_q   <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            load_q   <= load_d;
            count_q  <= count_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
        end
    end

    // Register read mux; registered by the top
    always_comb begin
        rdata_o = '0;
        case (reg_i)
            RegCtrl:    rdata_o = DATA_W'(ctrl_q);
            RegLoadLo:  rdata_o = load_q[DATA_W-1:0];
            RegLoadHi:  rdata_o = load_q[W2-1:DATA_W];
            RegCountLo: rdata_o = count_q[DATA_W-1:0];
            RegCountHi: rdata_o = shadow_q;
            RegStatus:  rdata_o = DATA_W'(pend_q);
            default: ;
        endcase
    end

    assign pend_o = pend_q;
    assign irq_o  = pend_q & ctrl_q[CtrlIrqEn];

endmodule

// File: rtl/iob_timer_mc.sv
// Multi-channel down-counter timer on the IOb native bus with a shared prescaler.
module iob_timer_mc
    import iob_timer_mc_pkg::*;
#(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned CNT_W   = 48,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PRESC_W = 16,
    parameter int unsigned ADDR_W  = $clog2(N_CH + 1) + 3
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic [N_CH-1:0]     irq
);

    localparam int unsigned IdxW = ADDR_W - 3;

    logic [IdxW-1:0]    ch_idx;
    logic [2:0]         reg_sel;
    logic               is_wr;
    logic               glb_sel;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic               tick;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               ready_q;
    logic [DATA_W-1:0]  ch_rdata [N_CH];
    logic [N_CH-1:0]    ch_pend;

    assign ch_idx  = address[ADDR_W-1:3];
    assign reg_sel = address[2:0];
    assign is_wr   = |wstrb;
    assign glb_sel = valid && (ch_idx == IdxW'(N_CH));
    assign tick    = (pcnt_q == presc_q);

    // Prescaler: counts 0..PRESC, a PRESC write restarts it from 0
    always_comb begin
        presc_d = presc_q;
        pcnt_d  = tick ? '0 : pcnt_q + 1'b1;
        if (glb_sel && is_wr && (reg_sel == RegPresc)) begin
            presc_d = wdata[PRESC_W-1:0];
            pcnt_d  = '0;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic sel;
        assign sel = valid && (ch_idx == IdxW'(g));

        iob_timer_mc_ch #(
            .CNT_W  (CNT_W),
            .DATA_W (DATA_W)
        ) u_ch (
            .clk     (clk),
            .arst_n  (arst_n),
            .tick_i  (tick),
            .wr_i    (sel && is_wr),
            .rd_i    (sel && !is_wr),
            .reg_i   (reg_sel),
            .wdata_i (wdata),
            .rdata_o (ch_rdata[g]),
            .pend_o  (ch_pend[g]),
            .irq_o   (irq[g])
        );
    end

    // Read data select; writes and unmapped addresses return 0
    always_comb begin
        rdata_d = '0;
        if (valid && !is_wr) begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch_idx == IdxW'(i)) begin
                    rdata_d = ch_rdata[i];
                end
            end
            if (glb_sel) begin
                case (reg_sel)
                    RegPresc:   rdata_d = DATA_W'(presc_q);
                    RegPendAll: rdata_d = DATA_W'(ch_pend);
                    default: ;
                endcase
            end
        end
    end

    // Prescaler state and one-cycle bus response
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            presc_q <= '0;
            pcnt_q  <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            rdata_q <= rdata_d;
            ready_q <= valid;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_iob_timer_mc.sv
// Scoreboard bench for iob_timer_mc: accesses push expectations, a monitor checks on ready.
module tb_iob_timer_mc;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        valid;
    logic [5:0]  address;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    logic [3:0]  irq;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        chk;
        logic [31:0] exp;
        string       nm;
    } exp_t;

    exp_t sb[$];

    iob_timer_mc dut (
        .clk     (clk),
        .arst_n  (arst_n),
        .valid   (valid),
        .address (address),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .rdata   (rdata),
        .ready   (ready),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [5:0] ad(input int ch, input int r);
        logic [2:0] c;
        logic [2:0] rr;
        c  = ch[2:0];
        rr = r[2:0];
        return {c, rr};
    endfunction

    task automatic acc(input logic [5:0] a, input logic w, input logic [31:0] d,
                       input logic c, input logic [31:0] e, input string nm);
        exp_t x;
        @(negedge clk);
        valid   = 1'b1;
        address = a;
        wdata   = w ? d : 32'h0;
        wstrb   = w ? 4'hF : 4'h0;
        x.chk = c;
        x.exp = e;
        x.nm  = nm;
        sb.push_back(x);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        acc(a, 1'b1, d, 1'b0, 32'h0, "wr");
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] e, input string nm);
        acc(a, 1'b0, 32'h0, 1'b1, e, nm);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid = 1'b0;
            wstrb = 4'h0;
        end
    endtask

    // Monitor: every ready pops one expectation
    always @(negedge clk) begin
        exp_t e;
        if (arst_n && ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ready: got ready=1 required no response");
            end else begin
                e = sb.pop_front();
                if (e.chk) cmp(e.nm, rdata, e.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "timeout");
    end

    logic [31:0] t1_exp [5]  = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3};
    // Reads of channel k%4 at consecutive slots after all four channels are running
    logic [31:0] t5_exp [16] = '{32'd1, 32'd0, 32'd1, 32'd2,
                                 32'd0, 32'd1, 32'd0, 32'd5,
                                 32'd2, 32'd2, 32'd2, 32'd1,
                                 32'd1, 32'd3, 32'd1, 32'd4};

    initial begin
        arst_n  = 1'b0;
        valid   = 1'b0;
        address = '0;
        wdata   = '0;
        wstrb   = '0;
        #2;
        cmp("rst_ready", 32'(ready), 32'h0);
        cmp("rst_irq", 32'(irq), 32'h0);
        cmp("rst_rdata", rdata, 32'h0);
        @(negedge clk);
        arst_n = 1'b1;

        rd(ad(0, 0), 32'h0, "rst_ctrl0");
        rd(ad(4, 0), 32'h0, "rst_presc");
        rd(ad(5, 0), 32'h0, "unmapped");
        wr(ad(0, 6), 32'hFFFF_FFFF);
        rd(ad(0, 6), 32'h0, "reg6_zero");

        // Periodic LOAD=3, PRESC=0
        wr(ad(0, 1), 32'd3);
        wr(ad(0, 0), 32'd5);
        for (int i = 0; i < 5; i++) begin
            rd(ad(0, 3), t1_exp[i], "t1_count");
            if (i == 3) cmp("t1_irq_before", 32'(irq[0]), 32'h0);
            if (i == 4) cmp("t1_irq_after", 32'(irq[0]), 32'h1);
        end
        rd(ad(0, 5), 32'h1, "t1_pend");
        wr(ad(0, 0), 32'h0);
        wr(ad(0, 5), 32'h1);
        rd(ad(0, 5), 32'h0, "t1_pend_clr");
        cmp("t1_irq_clr", 32'(irq[0]), 32'h0);

        // One-shot, PRESC=2, enable coincident with a prescaler tick
        wr(ad(4, 0), 32'd2);
        wr(ad(1, 1), 32'd1);
        idle(1);
        wr(ad(1, 0), 32'd7);
        rd(ad(1, 3), 32'd1, "t2_load_wins");
        idle(4);
        rd(ad(1, 5), 32'h0, "t2_pend_early");
        cmp("t2_irq_early", 32'(irq[1]), 32'h0);
        rd(ad(1, 5), 32'h1, "t2_pend");
        cmp("t2_irq", 32'(irq[1]), 32'h1);
        rd(ad(1, 0), 32'd6, "t2_en_cleared");
        rd(ad(4, 1), 32'h2, "t2_pend_all");
        rd(ad(1, 3), 32'h0, "t2_count_hold");
        wr(ad(1, 5), 32'h1);
        idle(8);
        rd(ad(1, 5), 32'h0, "t2_no_more_events");
        cmp("t2_irq_clr", 32'(irq[1]), 32'h0);
        rd(ad(4, 0), 32'd2, "t2_presc_rb");
        wr(ad(4, 0), 32'd0);

        // 48-bit coherent readout across the low-word wrap
        wr(ad(3, 1), 32'd2);
        wr(ad(3, 2), 32'd1);
        wr(ad(3, 0), 32'd1);
        idle(1);
        rd(ad(3, 3), 32'h1, "t3_lo_a");
        rd(ad(3, 4), 32'h1, "t3_hi_a");
        rd(ad(3, 3), 32'hFFFF_FFFF, "t3_lo_b");
        rd(ad(3, 4), 32'h0, "t3_hi_b");
        rd(ad(3, 2), 32'h1, "t3_load_hi");
        wr(ad(3, 0), 32'h0);

        // W1C on an event cycle vs a quiet cycle
        wr(ad(2, 1), 32'd0);
        wr(ad(2, 0), 32'd5);
        idle(2);
        wr(ad(2, 5), 32'h1);
        rd(ad(2, 5), 32'h1, "t4_event_wins");
        wr(ad(2, 0), 32'd4);
        wr(ad(2, 5), 32'h1);
        cmp("t4_irq_hold", 32'(irq[2]), 32'h1);
        rd(ad(2, 5), 32'h0, "t4_pend_clr");
        cmp("t4_irq_drop", 32'(irq[2]), 32'h0);

        // Four channels concurrently; ch2 LOAD changed mid-period
        wr(ad(3, 2), 32'd0);
        wr(ad(0, 1), 32'd2);
        wr(ad(1, 1), 32'd4);
        wr(ad(2, 1), 32'd5);
        wr(ad(3, 1), 32'd6);
        for (int c = 0; c < 4; c++) wr(ad(c, 0), 32'd5);
        wr(ad(2, 1), 32'd2);
        for (int k = 0; k < 16; k++) rd(ad(k % 4, 3), t5_exp[k], $sformatf("t5_ch%0d_k%0d", k % 4, k));
        cmp("t5_irq_all", 32'(irq), 32'hF);

        // Asynchronous reset mid-count
        acc(ad(0, 0), 1'b0, 32'h0, 1'b0, 32'h0, "t6_inflight");
        @(posedge clk);
        #1;
        cmp("t6_pre_ready", 32'(ready), 32'h1);
        cmp("t6_pre_rdata", rdata, 32'd5);
        arst_n = 1'b0;
        valid  = 1'b0;
        wstrb  = 4'h0;
        #1;
        cmp("t6_ready", 32'(ready), 32'h0);
        cmp("t6_rdata", rdata, 32'h0);
        cmp("t6_irq", 32'(irq), 32'h0);
        sb.delete();
        @(negedge clk);
        arst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            rd(ad(c, 0), 32'h0, $sformatf("t6_ctrl%0d", c));
            rd(ad(c, 3), 32'h0, $sformatf("t6_count%0d", c));
            rd(ad(c, 5), 32'h0, $sformatf("t6_pend%0d", c));
        end
        idle(3);
        cmp("t6_irq_after", 32'(irq), 32'h0);
        cmp("sb_drained", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
